// File: rtl/fir_symmetry_mc_sequencer.sv
// Frame sequencer and coefficient store for a time-multiplexed symmetric FIR chain.
// Define FIR_SEQ_BANK_SWAP_EN for double-buffered coefficients committed at frame boundaries.
module fir_symmetry_mc_sequencer #(
  parameter int DW  = 16,
  parameter int N   = 8,
  parameter int LGN = 3
) (
  input  logic                 clk_sample,
  input  logic                 reset_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_ce,
  output logic [LGN-1:0]       o_cycle,
  output logic signed [DW-1:0] o_coeff,
  output logic                 o_frame_start,
  output logic                 o_out_valid,
  input  logic                 i_cfg_wr_en,
  output logic                 o_cfg_wr_ready,
  input  logic [LGN-1:0]       i_cfg_wr_addr,
  input  logic signed [DW-1:0] i_cfg_wr_data,
  input  logic                 i_cfg_commit,
  output logic                 o_cfg_busy
);

  localparam logic [LGN-1:0] LAST = LGN'(N - 1);
  localparam logic [LGN:0]   NW   = (LGN + 1)'(N);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state, w_stateNext;
  logic [LGN-1:0]       r_cycle, w_cycleNext;
  logic signed [DW-1:0] r_coeff, w_coeffNext;
  logic                 r_outValid;
  logic signed [DW-1:0] r_active [N];
  logic                 w_last, w_accept, w_wrHit;

  assign w_last         = (r_state == S_RUN) && (r_cycle == LAST);
  assign o_in_ready     = (r_state == S_IDLE) || w_last;
  assign w_accept       = i_in_valid && o_in_ready;
  assign w_wrHit        = i_cfg_wr_en && o_cfg_wr_ready && ({1'b0, i_cfg_wr_addr} < NW);

  assign o_ce           = (r_state == S_RUN);
  assign o_cycle        = r_cycle;
  assign o_coeff        = r_coeff;
  assign o_frame_start  = o_ce && (r_cycle == '0);
  assign o_out_valid    = r_outValid;

  always_comb begin
    w_stateNext = r_state;
    w_cycleNext = r_cycle;
    case (r_state)
      S_IDLE: begin
        w_cycleNext = '0;
        if (w_accept) w_stateNext = S_RUN;
      end
      S_RUN: begin
        if (w_last) begin
          w_cycleNext = '0;
          w_stateNext = w_accept ? S_RUN : S_IDLE;
        end else begin
          w_cycleNext = r_cycle + 1'b1;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_cycleNext = '0;
      end
    endcase
  end

  // coeff is registered alongside cycle, so it is looked up with the next cycle index
  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cycle    <= '0;
      r_coeff    <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cycle    <= w_cycleNext;
      r_coeff    <= w_coeffNext;
      r_outValid <= w_last;
    end
  end

`ifdef FIR_SEQ_BANK_SWAP_EN
  logic signed [DW-1:0] r_shadow [N];
  logic                 r_pending;
  logic                 w_swap;

  // Swap only where a frame cannot be mid-flight: idle, or on its final cycle
  assign w_swap         = r_pending && ((r_state == S_IDLE) || w_last);
  assign o_cfg_wr_ready = !r_pending;
  assign o_cfg_busy     = r_pending;

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wrHit) r_shadow[i_cfg_wr_addr] <= i_cfg_wr_data;
      if (w_swap) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (i_cfg_commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_coeffNext = w_swap ? r_shadow[w_cycleNext] : r_active[w_cycleNext];
  end
`else
  logic w_unusedCommit;

  assign w_unusedCommit = i_cfg_commit;
  assign o_cfg_wr_ready = 1'b1;
  assign o_cfg_busy     = 1'b0;

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_active[i] <= '0;
    end else if (w_wrHit) begin
      r_active[i_cfg_wr_addr] <= i_cfg_wr_data;
    end
  end

  // A write landing on the entry about to be presented must show up in coeff at once
  always_comb begin
    w_coeffNext = r_active[w_cycleNext];
    if (w_wrHit && (i_cfg_wr_addr == w_cycleNext)) w_coeffNext = i_cfg_wr_data;
  end
`endif

endmodule

// File: tb/tb_fir_symmetry_mc_sequencer.sv
// Self-checking bench for fir_symmetry_mc_sequencer (N=8 main instance, N=5 instance for address range).
// Follows FIR_SEQ_BANK_SWAP_EN the same way the design does.
module tb_fir_symmetry_mc_sequencer;
  localparam int DW = 16, N = 8, LGN = 3, N5 = 5;

  logic clk_sample = 1'b0, reset_n = 1'b0;
  logic i_in_valid = 1'b0, i_cfg_wr_en = 1'b0, i_cfg_commit = 1'b0;
  logic [LGN-1:0] i_cfg_wr_addr = '0;
  logic signed [DW-1:0] i_cfg_wr_data = '0;
  logic o_in_ready, o_ce, o_frame_start, o_out_valid, o_cfg_wr_ready, o_cfg_busy;
  logic [LGN-1:0] o_cycle;
  logic signed [DW-1:0] o_coeff;

  logic d5_in_valid = 1'b0, d5_wr_en = 1'b0, d5_commit = 1'b0;
  logic [LGN-1:0] d5_wr_addr = '0;
  logic signed [DW-1:0] d5_wr_data = '0;
  logic d5_in_ready, d5_ce, d5_frame_start, d5_out_valid, d5_wr_ready, d5_busy;
  logic [LGN-1:0] d5_cycle;
  logic signed [DW-1:0] d5_coeff;

  int nCompared = 0, nMismatched = 0;

  // Reference model: active/shadow banks plus a queue of the cycle indices still to be shown
  logic signed [DW-1:0] mActive [N];
  logic signed [DW-1:0] mShadow [N];
  bit mPend;
  bit mOv;
  int sched[$];

  fir_symmetry_mc_sequencer #(.DW(DW), .N(N), .LGN(LGN)) u_dut (
    .clk_sample(clk_sample), .reset_n(reset_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_ce(o_ce), .o_cycle(o_cycle),
    .o_coeff(o_coeff), .o_frame_start(o_frame_start), .o_out_valid(o_out_valid),
    .i_cfg_wr_en(i_cfg_wr_en), .o_cfg_wr_ready(o_cfg_wr_ready), .i_cfg_wr_addr(i_cfg_wr_addr),
    .i_cfg_wr_data(i_cfg_wr_data), .i_cfg_commit(i_cfg_commit), .o_cfg_busy(o_cfg_busy)
  );

  fir_symmetry_mc_sequencer #(.DW(DW), .N(N5), .LGN(LGN)) u_dut5 (
    .clk_sample(clk_sample), .reset_n(reset_n),
    .i_in_valid(d5_in_valid), .o_in_ready(d5_in_ready), .o_ce(d5_ce), .o_cycle(d5_cycle),
    .o_coeff(d5_coeff), .o_frame_start(d5_frame_start), .o_out_valid(d5_out_valid),
    .i_cfg_wr_en(d5_wr_en), .o_cfg_wr_ready(d5_wr_ready), .i_cfg_wr_addr(d5_wr_addr),
    .i_cfg_wr_data(d5_wr_data), .i_cfg_commit(d5_commit), .o_cfg_busy(d5_busy)
  );

  always #5 clk_sample = ~clk_sample;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mActive[k] = '0;
      mShadow[k] = '0;
    end
    mPend = 1'b0;
    mOv   = 1'b0;
    sched.delete();
  endfunction

  function automatic bit expCe();
    return sched.size() > 0;
  endfunction

  function automatic int expCycle();
    return (sched.size() > 0) ? sched[0] : 0;
  endfunction

  function automatic bit expReady();
    return sched.size() <= 1;
  endfunction

  function automatic logic signed [DW-1:0] expCoeff();
    return mActive[expCycle()];
  endfunction

  function automatic bit expBusy();
`ifdef FIR_SEQ_BANK_SWAP_EN
    return mPend;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model across one rising edge using the inputs currently applied
  function automatic void model_edge();
    bit acc, frameDone;
    acc       = i_in_valid && expReady();
    frameDone = (sched.size() == 1);
`ifdef FIR_SEQ_BANK_SWAP_EN
    if (i_cfg_wr_en && !mPend && int'(i_cfg_wr_addr) < N) mShadow[i_cfg_wr_addr] = i_cfg_wr_data;
    if (mPend && sched.size() <= 1) begin
      mActive = mShadow;
      mPend   = 1'b0;
    end else if (i_cfg_commit) begin
      mPend = 1'b1;
    end
`else
    if (i_cfg_wr_en && int'(i_cfg_wr_addr) < N) mActive[i_cfg_wr_addr] = i_cfg_wr_data;
`endif
    if (sched.size() > 0) void'(sched.pop_front());
    if (acc) for (int k = 0; k < N; k++) sched.push_back(k);
    mOv = frameDone;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic idle_inputs();
    i_in_valid = 1'b0; i_cfg_wr_en = 1'b0; i_cfg_commit = 1'b0;
  endtask

  task automatic load_random_bank();
    for (int k = 0; k < N; k++) begin
      i_cfg_wr_en = 1'b1; i_cfg_wr_addr = LGN'(k); i_cfg_wr_data = DW'($urandom) | 16'sd1;
      tick();
    end
    i_cfg_wr_en = 1'b0; i_cfg_commit = 1'b1;
    tick();
    i_cfg_commit = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    nCompared++; if (o_in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %0d expected 1", o_in_ready); end
    nCompared++; if (o_ce !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ce: got %0d expected 0", o_ce); end
    nCompared++; if (o_cycle !== '0) begin nMismatched++; $display("[TB] FAIL reset_cycle: got %0d expected 0", o_cycle); end
    nCompared++; if (o_coeff !== '0) begin nMismatched++; $display("[TB] FAIL reset_coeff: got %0d expected 0", o_coeff); end
    nCompared++; if (o_out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %0d expected 0", o_out_valid); end
    nCompared++; if (o_cfg_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0d expected 0", o_cfg_busy); end
    @(negedge clk_sample);
    reset_n = 1'b1;
    tick();
    nCompared++; if (o_ce !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_ce: got %0d expected 0", o_ce); end
    nCompared++; if (o_cfg_wr_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL idle_wr_ready: got %0d expected 1", o_cfg_wr_ready); end
  endtask

  task automatic test_single_sample();
    int ceCount = 0, ovCount = 0, ovAt = -1;
    load_random_bank();
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      nCompared++; if (o_ce !== expCe()) begin nMismatched++; $display("[TB] FAIL single_ce[%0d]: got %0d expected %0d", i, o_ce, expCe()); end
      nCompared++; if (int'(o_cycle) !== expCycle()) begin nMismatched++; $display("[TB] FAIL single_cycle[%0d]: got %0d expected %0d", i, o_cycle, expCycle()); end
      nCompared++; if (o_coeff !== expCoeff()) begin nMismatched++; $display("[TB] FAIL single_coeff[%0d]: got %0d expected %0d", i, o_coeff, expCoeff()); end
      nCompared++; if (o_frame_start !== (i == 0)) begin nMismatched++; $display("[TB] FAIL single_frame_start[%0d]: got %0d expected %0d", i, o_frame_start, i == 0); end
      nCompared++; if (o_out_valid !== mOv) begin nMismatched++; $display("[TB] FAIL single_out_valid[%0d]: got %0d expected %0d", i, o_out_valid, mOv); end
      if (o_ce === 1'b1) ceCount++;
      if (o_out_valid === 1'b1) begin ovCount++; ovAt = i; end
      tick();
    end
    nCompared++; if (ceCount != N) begin nMismatched++; $display("[TB] FAIL single_ce_count: got %0d expected %0d", ceCount, N); end
    nCompared++; if (ovCount != 1 || ovAt != N) begin nMismatched++; $display("[TB] FAIL single_ov_position: got count %0d at %0d expected 1 at %0d", ovCount, ovAt, N); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0, ceCount = 0, firstCe = -1, lastCe = -1;
    int ovIdx[$];
    i_in_valid = 1'b1;
    for (int i = 0; i < 3 * N + 4; i++) begin
      if (i_in_valid && expReady()) accepts++;
      tick();
      if (accepts == 3) i_in_valid = 1'b0;
      nCompared++; if (o_ce !== expCe()) begin nMismatched++; $display("[TB] FAIL b2b_ce[%0d]: got %0d expected %0d", i, o_ce, expCe()); end
      nCompared++; if (int'(o_cycle) !== expCycle()) begin nMismatched++; $display("[TB] FAIL b2b_cycle[%0d]: got %0d expected %0d", i, o_cycle, expCycle()); end
      nCompared++; if (o_in_ready !== expReady()) begin nMismatched++; $display("[TB] FAIL b2b_in_ready[%0d]: got %0d expected %0d", i, o_in_ready, expReady()); end
      nCompared++; if (o_out_valid !== mOv) begin nMismatched++; $display("[TB] FAIL b2b_out_valid[%0d]: got %0d expected %0d", i, o_out_valid, mOv); end
      if (o_ce === 1'b1) begin
        ceCount++;
        if (firstCe < 0) firstCe = i;
        lastCe = i;
      end
      if (o_out_valid === 1'b1) ovIdx.push_back(i);
    end
    nCompared++; if (ceCount != 3 * N || lastCe - firstCe + 1 != 3 * N) begin nMismatched++; $display("[TB] FAIL b2b_ce_run: got %0d ce over span %0d expected %0d contiguous", ceCount, lastCe - firstCe + 1, 3 * N); end
    nCompared++; if (ovIdx.size() != 3 || ovIdx[1] - ovIdx[0] != N || ovIdx[2] - ovIdx[1] != N) begin nMismatched++; $display("[TB] FAIL b2b_ov_spacing: got %0d pulses expected 3 spaced %0d", ovIdx.size(), N); end
  endtask

  task automatic test_bank_swap();
    logic signed [DW-1:0] oldBank [N];
    logic signed [DW-1:0] f1Exp;
    bit busyPlan;
    int accepts = 0, frameIdx = 0;
    for (int k = 0; k < N; k++) oldBank[k] = mActive[k];
    for (int k = 0; k < N; k++) begin
      i_cfg_wr_en = 1'b1; i_cfg_wr_addr = LGN'(k); i_cfg_wr_data = DW'(100 + k);
      tick();
    end
    i_cfg_wr_en = 1'b0;
    i_in_valid = 1'b1;
    for (int i = 0; i < 2 * N + 3; i++) begin
      i_cfg_commit = (frameIdx == 1 && expCe() && expCycle() == 3);
      if (i_in_valid && expReady()) accepts++;
      tick();
      if (accepts == 2) i_in_valid = 1'b0;
      if (expCe() && expCycle() == 0) frameIdx++;
`ifdef FIR_SEQ_BANK_SWAP_EN
      f1Exp    = oldBank[expCycle()];
      busyPlan = (frameIdx == 1 && expCe() && expCycle() >= 4);
`else
      f1Exp    = DW'(100 + expCycle());
      busyPlan = 1'b0;
`endif
      nCompared++; if (o_coeff !== expCoeff()) begin nMismatched++; $display("[TB] FAIL swap_coeff_model[%0d]: got %0d expected %0d", i, o_coeff, expCoeff()); end
      if (expCe() && frameIdx == 1) begin
        nCompared++; if (o_coeff !== f1Exp) begin nMismatched++; $display("[TB] FAIL swap_frame1_coeff[%0d]: got %0d expected %0d", i, o_coeff, f1Exp); end
      end
      if (expCe() && frameIdx == 2) begin
        nCompared++; if (o_coeff !== DW'(100 + expCycle())) begin nMismatched++; $display("[TB] FAIL swap_frame2_coeff[%0d]: got %0d expected %0d", i, o_coeff, 100 + expCycle()); end
      end
      nCompared++; if (o_cfg_busy !== busyPlan) begin nMismatched++; $display("[TB] FAIL swap_busy[%0d]: got %0d expected %0d", i, o_cfg_busy, busyPlan); end
      nCompared++; if (o_cfg_wr_ready !== !busyPlan) begin nMismatched++; $display("[TB] FAIL swap_wr_ready[%0d]: got %0d expected %0d", i, o_cfg_wr_ready, !busyPlan); end
    end
    i_cfg_commit = 1'b0;
  endtask

  task automatic test_corner_same_clock();
    logic signed [DW-1:0] oldV, newV;
    oldV = mActive[0];
    newV = oldV ^ 16'sh5A5A;
    i_cfg_wr_en = 1'b1; i_cfg_wr_addr = '0; i_cfg_wr_data = newV; i_cfg_commit = 1'b1;
    tick();
    idle_inputs();
`ifdef FIR_SEQ_BANK_SWAP_EN
    nCompared++; if (o_coeff !== oldV) begin nMismatched++; $display("[TB] FAIL corner_coeff_1clk: got %0d expected %0d", o_coeff, oldV); end
    nCompared++; if (o_cfg_busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL corner_busy: got %0d expected 1", o_cfg_busy); end
`else
    nCompared++; if (o_coeff !== newV) begin nMismatched++; $display("[TB] FAIL corner_coeff_1clk: got %0d expected %0d", o_coeff, newV); end
`endif
    tick();
    nCompared++; if (o_coeff !== newV) begin nMismatched++; $display("[TB] FAIL corner_coeff_2clk: got %0d expected %0d", o_coeff, newV); end
    nCompared++; if (o_cfg_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL corner_busy_clear: got %0d expected 0", o_cfg_busy); end
  endtask

  task automatic test_addr_discard();
    logic signed [DW-1:0] val2;
    val2 = DW'($urandom) | 16'sd2;
    for (int a = 5; a < 8; a++) begin
      d5_wr_en = 1'b1; d5_wr_addr = LGN'(a); d5_wr_data = DW'($urandom) | 16'sd1;
      tick();
    end
    d5_wr_addr = 3'd2; d5_wr_data = val2;
    tick();
    d5_wr_en = 1'b0; d5_commit = 1'b1;
    tick();
    d5_commit = 1'b0;
    tick(); tick();
    nCompared++; if (d5_busy !== 1'b0 || d5_wr_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL d5_cfg_idle: got busy %0d ready %0d expected 0 1", d5_busy, d5_wr_ready); end
    d5_in_valid = 1'b1;
    tick();
    d5_in_valid = 1'b0;
    for (int c = 0; c < N5; c++) begin
      nCompared++; if (int'(d5_cycle) !== c || d5_ce !== 1'b1) begin nMismatched++; $display("[TB] FAIL d5_cycle[%0d]: got %0d ce %0d expected %0d ce 1", c, d5_cycle, d5_ce, c); end
      nCompared++; if (d5_coeff !== ((c == 2) ? val2 : 16'sd0)) begin nMismatched++; $display("[TB] FAIL d5_coeff[%0d]: got %0d expected %0d", c, d5_coeff, (c == 2) ? val2 : 16'sd0); end
      nCompared++; if (d5_in_ready !== (c == N5 - 1) || d5_frame_start !== (c == 0)) begin nMismatched++; $display("[TB] FAIL d5_ready_fs[%0d]: got %0d %0d expected %0d %0d", c, d5_in_ready, d5_frame_start, c == N5 - 1, c == 0); end
      tick();
    end
    nCompared++; if (d5_out_valid !== 1'b1 || d5_ce !== 1'b0) begin nMismatched++; $display("[TB] FAIL d5_end: got ov %0d ce %0d expected 1 0", d5_out_valid, d5_ce); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      i_in_valid    = ($urandom_range(0, 3) != 0);
      i_cfg_wr_en   = ($urandom_range(0, 2) == 0);
      i_cfg_wr_addr = LGN'($urandom_range(0, N - 1));
      i_cfg_wr_data = DW'($urandom);
      i_cfg_commit  = ($urandom_range(0, 7) == 0);
      nCompared++; if (o_ce !== expCe()) begin nMismatched++; $display("[TB] FAIL rnd_ce[%0d]: got %0d expected %0d", i, o_ce, expCe()); end
      nCompared++; if (int'(o_cycle) !== expCycle()) begin nMismatched++; $display("[TB] FAIL rnd_cycle[%0d]: got %0d expected %0d", i, o_cycle, expCycle()); end
      nCompared++; if (o_coeff !== expCoeff()) begin nMismatched++; $display("[TB] FAIL rnd_coeff[%0d]: got %0d expected %0d", i, o_coeff, expCoeff()); end
      nCompared++; if (o_frame_start !== (expCe() && expCycle() == 0)) begin nMismatched++; $display("[TB] FAIL rnd_frame_start[%0d]: got %0d", i, o_frame_start); end
      nCompared++; if (o_out_valid !== mOv) begin nMismatched++; $display("[TB] FAIL rnd_out_valid[%0d]: got %0d expected %0d", i, o_out_valid, mOv); end
      nCompared++; if (o_in_ready !== expReady()) begin nMismatched++; $display("[TB] FAIL rnd_in_ready[%0d]: got %0d expected %0d", i, o_in_ready, expReady()); end
      nCompared++; if (o_cfg_busy !== expBusy()) begin nMismatched++; $display("[TB] FAIL rnd_busy[%0d]: got %0d expected %0d", i, o_cfg_busy, expBusy()); end
      nCompared++; if (o_cfg_wr_ready !== !expBusy()) begin nMismatched++; $display("[TB] FAIL rnd_wr_ready[%0d]: got %0d expected %0d", i, o_cfg_wr_ready, !expBusy()); end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 2 * N + 2; i++) tick();
  endtask

  task automatic test_reset_midframe();
    load_random_bank();
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (expCycle() == 4) break;
      i_cfg_wr_en  = (expCycle() == 1);
      i_cfg_commit = (expCycle() == 2);
      i_cfg_wr_addr = 3'd5; i_cfg_wr_data = 16'sh0777;
      tick();
    end
    idle_inputs();
    nCompared++; if (o_cycle !== 3'd4) begin nMismatched++; $display("[TB] FAIL rst_pre_cycle: got %0d expected 4", o_cycle); end
    reset_n = 1'b0;
    model_reset();
    #2;
    nCompared++; if (o_ce !== 1'b0 || o_cycle !== '0) begin nMismatched++; $display("[TB] FAIL rst_ce_cycle: got ce %0d cycle %0d expected 0 0", o_ce, o_cycle); end
    nCompared++; if (o_out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_out_valid: got %0d expected 0", o_out_valid); end
    nCompared++; if (o_cfg_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_busy: got %0d expected 0", o_cfg_busy); end
    nCompared++; if (o_coeff !== '0) begin nMismatched++; $display("[TB] FAIL rst_coeff: got %0d expected 0", o_coeff); end
    @(negedge clk_sample);
    reset_n = 1'b1;
    tick();
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      nCompared++; if (o_coeff !== 16'sd0) begin nMismatched++; $display("[TB] FAIL rst_bank_zero[%0d]: got %0d expected 0", i, o_coeff); end
      nCompared++; if (o_out_valid !== mOv) begin nMismatched++; $display("[TB] FAIL rst_out_valid_after[%0d]: got %0d expected %0d", i, o_out_valid, mOv); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_back_to_back();
    test_bank_swap();
    test_corner_same_clock();
    test_addr_discard();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fir_symmetry_mc_sequencer.md
Name: fir_symmetry_mc_sequencer

Overview:
Sequencer and coefficient store for a time-multiplexed chain of symmetric FIR sections with modifiable coefficients.
- Accepts one input sample per frame through a valid/ready handshake.
- Drives the chain's shared ce and the cycle index, which steps 0..N-1 in each frame.
- Presents the coefficient for the current cycle.
- Flags when the endpoint result is valid.
- Holds a write-only configuration port. Coefficient updates take effect only at frame boundaries, so a frame never mixes coefficients.

Parameters:
DW, 16, sample and coefficient width
N, 8, cycles per frame (taps per section pass); N >= 2
LGN, 3, width of the cycle index; 2^LGN >= N

Ports:
clk_sample  in  1  sample-rate processing clock
reset_n  in  1  async reset, active-low
in_valid  in  1  new sample available to the chain
in_ready  out  1  sequencer accepts a sample this clock
ce  out  1  clock enable to every FIR section and the endpoint
cycle  out  LGN  current cycle index, 0..N-1
coeff  out  DW  signed coefficient for the current cycle
frame_start  out  1  high when ce=1 and cycle=0
out_valid  out  1  one-clock pulse: endpoint result updated with the completed frame
cfg_wr_en  in  1  coefficient write strobe
cfg_wr_ready  out  1  write accepted when high
cfg_wr_addr  in  LGN  coefficient index
cfg_wr_data  in  DW  signed coefficient value
cfg_commit  in  1  one-clock request to activate the written coefficients
cfg_busy  out  1  commit pending, not yet applied

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, cycle=0, ce=0, out_valid=0, coeff=0, pending=0.
  - Both coefficient banks are cleared to 0.
  - Reset mid-frame aborts the frame; no out_valid is produced.
- FSM has two states, IDLE and RUN.
  - IDLE: ce=0, cycle=0, in_ready=1. An accepted sample (in_valid & in_ready) moves to RUN with cycle=0 and ce=1 on the next clock.
  - RUN: ce=1 and cycle increments by 1 every clock.
  - in_ready=1 only when cycle=N-1.
  - At cycle=N-1 with in_valid=1: the next sample is accepted, cycle wraps to 0 and ce stays 1. Back-to-back frames have no bubble.
  - At cycle=N-1 with in_valid=0: the FSM returns to IDLE and ce=0 on the next clock.
  - in_valid asserted while in_ready=0 is held by the source; no sample is lost and no error is raised.
- cycle and coeff are both registered and update on the same edge. coeff always equals active_bank[cycle].
- out_valid pulses for one clock, on the clock after the ce cycle with cycle=N-1. This gives one pulse per frame, with latency N+1 clocks from acceptance.
- Coefficient writes:
  - Written when cfg_wr_en & cfg_wr_ready.
  - Go to the shadow bank at cfg_wr_addr.
  - An address >= N is accepted and discarded.
- cfg_wr_ready = !pending.
- cfg_commit sets pending, so cfg_busy=1 from the next clock.
- Bank swap (shadow copied to active, pending cleared):
  - In IDLE: on the clock after pending is set.
  - In RUN: on the edge where cycle wraps from N-1 to 0, or where the FSM leaves RUN for IDLE.
  - The next frame uses the new bank from cycle 0.
- A write and a commit in the same clock: the write lands first and is included in the commit.
- A commit while pending=1 is ignored.
- Coefficients are stored verbatim; no arithmetic is done in this block.

Optional Feature:
FIR_SEQ_BANK_SWAP_EN
- Defined: double-buffered banks, with commit behaviour as above.
- Undefined:
  - Single bank; writes go straight to the active bank and may change coeff mid-frame.
  - cfg_commit is ignored, cfg_busy is tied to 0 and cfg_wr_ready is tied to 1.

Test Plan:
- Reset then idle (N=8) -> in_ready=1, ce=0, cycle=0, coeff=0, out_valid=0, cfg_busy=0.
- Single sample (in_valid for 1 clock) -> ce high 8 clocks, cycle 0..7, frame_start on the first ce clock, out_valid 1 clock after cycle=7, then IDLE.
- in_valid held high for 3 frames -> 24 consecutive ce clocks, cycle wraps 7->0 with no gap, 3 out_valid pulses 8 clocks apart.
- Bank swap during RUN:
  - Setup: write coeff[k]=100+k for k=0..7, then cfg_commit at cycle=3.
  - Required: the current frame keeps the old values; the next frame shows coeff 100..107 aligned with cycle 0..7; cfg_busy drops at the wrap; cfg_wr_ready=0 while busy.
- Corner cases:
  - Write to addr 0 and commit in the same clock while in IDLE -> new coeff[0] active 2 clocks later.
  - Write to an address >= N -> no bank change.
- reset_n low at cycle=4 -> ce=0, cycle=0 immediately, no out_valid, pending cleared, banks zero.
